// File: rtl/ahbl_wrap4_master.sv
// Adapts a 128-bit line read/write request into one AHB-Lite WRAP4 burst of 32-bit beats.
// Optional critical-word-first ordering is enabled by defining AHBL_WRAP4_CRITICAL_WORD_EN.
module ahbl_wrap4_master #(
  parameter int unsigned W_HADDR   = 32,
  parameter int unsigned W_HDATA   = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [W_HADDR-1:0]     req_addr,
  input  logic [4*W_HDATA-1:0]   req_wdata,
  output logic                   resp_valid,
  output logic [4*W_HDATA-1:0]   resp_rdata,
  output logic                   resp_err,
  output logic [W_HADDR-1:0]     ahblm_haddr,
  output logic                   ahblm_hwrite,
  output logic [1:0]             ahblm_htrans,
  output logic [2:0]             ahblm_hsize,
  output logic [2:0]             ahblm_hburst,
  output logic [3:0]             ahblm_hprot,
  output logic                   ahblm_hmastlock,
  output logic [W_HDATA-1:0]     ahblm_hwdata,
  input  logic                   ahblm_hready,
  input  logic                   ahblm_hresp,
  input  logic [W_HDATA-1:0]     ahblm_hrdata
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   rdy_en_q;
  logic                   write_q, write_d;
  logic [4*W_HDATA-1:0]   wdata_q, wdata_d;
  logic [W_HADDR-5:0]     line_q, line_d;
  logic [1:0]             off0_q, off0_d;
  logic [2:0]             acnt_q, acnt_d;
  logic [1:0]             dcnt_q, dcnt_d;
  logic                   dact_q, dact_d;
  logic                   err_q, err_d;
  logic [4*W_HDATA-1:0]   rdata_q, rdata_d;
  logic                   resp_err_q, resp_err_d;

  logic [1:0]             req_off0;
  logic                   unused_addr;
  logic                   accept;
  logic                   addr_act;
  logic [1:0]             addr_ofs;
  logic [1:0]             data_ofs;

`ifdef AHBL_WRAP4_CRITICAL_WORD_EN
  assign req_off0    = req_addr[3:2];
  assign unused_addr = ^req_addr[1:0];
`else
  assign req_off0    = 2'd0;
  assign unused_addr = ^req_addr[3:0];
`endif

  assign req_ready = (state_q == S_IDLE) && rdy_en_q;
  assign accept    = req_valid && req_ready;

  // Any error response on the data phase kills further address phases in the same cycle.
  assign addr_act = (state_q == S_BURST) && !acnt_q[2] && !err_q &&
                    !(dact_q && ahblm_hresp);

  // Once all four address phases are issued, haddr stays on the last beat's address.
  assign addr_ofs = off0_q + (acnt_q[2] ? 2'd3 : acnt_q[1:0]);
  assign data_ofs = off0_q + dcnt_q;

  assign ahblm_haddr     = {line_q, addr_ofs, 2'b00};
  assign ahblm_hwrite    = write_q;
  assign ahblm_htrans    = addr_act ? ((acnt_q == 3'd0) ? HTRANS_NONSEQ : HTRANS_SEQ)
                                    : HTRANS_IDLE;
  assign ahblm_hsize     = 3'b010;
  assign ahblm_hburst    = 3'b010;
  assign ahblm_hprot     = HPROT_VAL;
  assign ahblm_hmastlock = 1'b0;
  assign ahblm_hwdata    = (dact_q && write_q) ? wdata_q[data_ofs*W_HDATA +: W_HDATA]
                                               : '0;

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    off0_d     = off0_q;
    acnt_d     = acnt_q;
    dcnt_d     = dcnt_q;
    dact_d     = dact_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d    = req_write;
          wdata_d    = req_wdata;
          line_d     = req_addr[W_HADDR-1:4];
          off0_d     = req_off0;
          acnt_d     = 3'd0;
          dcnt_d     = 2'd0;
          dact_d     = 1'b0;
          err_d      = 1'b0;
          resp_err_d = 1'b0;
          state_d    = S_BURST;
        end
      end

      S_BURST: begin
        if (addr_act && ahblm_hready) begin
          acnt_d = acnt_q + 3'd1;
        end
        if (ahblm_hready) begin
          dact_d = addr_act;
        end
        if (dact_q && ahblm_hresp && !ahblm_hready) begin
          err_d = 1'b1;
        end
        if (dact_q && ahblm_hready) begin
          if (!ahblm_hresp && !write_q) begin
            rdata_d[data_ofs*W_HDATA +: W_HDATA] = ahblm_hrdata;
          end
          dcnt_d = dcnt_q + 2'd1;
          if (ahblm_hresp || (dcnt_q == 2'd3)) begin
            resp_err_d = ahblm_hresp;
            state_d    = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rdy_en_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      line_q     <= '0;
      off0_q     <= 2'd0;
      acnt_q     <= 3'd0;
      dcnt_q     <= 2'd0;
      dact_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rdy_en_q   <= 1'b1;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      off0_q     <= off0_d;
      acnt_q     <= acnt_d;
      dcnt_q     <= dcnt_d;
      dact_q     <= dact_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_ahbl_wrap4_master.sv
// Scoreboard bench for ahbl_wrap4_master: AHB slave model plus line-level reference memory.
module tb_ahbl_wrap4_master;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;
  logic          resp_valid;
  logic [127:0]  resp_rdata;
  logic          resp_err;
  logic [31:0]   haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic          hmastlock;
  logic [31:0]   hwdata;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic [31:0]   hrdata = '0;

  ahbl_wrap4_master #(.W_HADDR(32), .W_HDATA(32), .HPROT_VAL(4'b0011)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
    .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
    .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
    .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] wd;
  } abeat_t;

  typedef struct {
    logic [127:0] rdata;
    logic         err;
  } resp_t;

  abeat_t       exp_aq[$];
  resp_t        exp_rq[$];
  logic [31:0]  smem[256];
  logic [31:0]  rmem[256];
  logic [127:0] last_rdata = '0;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int acc_cyc = 0;
  int resp_cyc = 0;
  int nonseq_cyc = 0;
  int resp_cnt = 0;
  bit busy = 1'b0;
  int cfg_err_beat = -1;
  int cfg_wait_beat = -1;
  int cfg_wait_n = 0;
  int cfg_maxw = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int off0_of(input logic [31:0] a);
`ifdef AHBL_WRAP4_CRITICAL_WORD_EN
    return int'((a / 4) % 4);
`else
    return 0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 256);
  endfunction

  task automatic cycle_counter();
    forever begin
      @(posedge clk);
      ncyc++;
    end
  endtask

  // AHB slave: random or configured wait states, optional two-cycle ERROR on one beat.
  task automatic slave_proc();
    bit          dp_act = 0, dp_wr = 0, dp_err = 0, newacc, prev_hold = 0;
    int          dp_errcyc = 0, dp_wait = 0, beat = 0;
    logic [31:0] dp_addr = '0, dp_wd = '0, wd_next, prev_addr = '0;
    logic [1:0]  prev_trans = '0;
    abeat_t      e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        dp_act = 0;
        prev_hold = 0;
        hready = 1'b1;
        hresp = 1'b0;
      end else begin
        if (dp_act) begin
          if (dp_err) begin
            hready = (dp_errcyc != 0);
            hresp = 1'b1;
          end else begin
            hready = (dp_wait == 0);
            hresp = 1'b0;
          end
          hrdata = (hready && !dp_err && !dp_wr) ? smem[widx(dp_addr)] : $urandom;
        end else begin
          hready = 1'b1;
          hresp = 1'b0;
          hrdata = $urandom;
        end
        #1;
        if (prev_hold) begin
          chk(haddr == prev_addr, "haddr_hold", haddr, prev_addr);
          chk(htrans == prev_trans, "htrans_hold", htrans, prev_trans);
        end
        if (dp_act && dp_wr && !dp_err)
          chk(hwdata == dp_wd, "hwdata", hwdata, dp_wd);
        if (dp_act && dp_err && dp_errcyc == 0)
          chk(htrans == 2'b00, "htrans_err_idle", htrans, 2'b00);
        newacc = hready && htrans[1];
        wd_next = '0;
        if (newacc) begin
          if (exp_aq.size() == 0) begin
            chk(1'b0, "unexpected_beat", haddr, 0);
          end else begin
            e = exp_aq.pop_front();
            chk(haddr == e.addr, "haddr", haddr, e.addr);
            chk(htrans == e.trans, "htrans", htrans, e.trans);
            chk(hwrite == e.wr, "hwrite", hwrite, e.wr);
            wd_next = e.wd;
          end
        end
        if (dp_act) begin
          if (dp_err) begin
            if (dp_errcyc == 0) dp_errcyc = 1;
            else dp_act = 0;
          end else if (dp_wait > 0) begin
            dp_wait--;
          end else begin
            if (dp_wr) smem[widx(dp_addr)] = hwdata;
            dp_act = 0;
          end
        end
        if (newacc) begin
          beat = (htrans == 2'b10) ? 0 : beat + 1;
          dp_act = 1;
          dp_wr = hwrite;
          dp_addr = haddr;
          dp_wd = wd_next;
          dp_err = (beat == cfg_err_beat);
          dp_errcyc = 0;
          dp_wait = (beat == cfg_wait_beat) ? cfg_wait_n : int'($urandom_range(0, cfg_maxw));
          if (dp_err) dp_wait = 0;
        end
        prev_hold = !hready && htrans[1];
        prev_addr = haddr;
        prev_trans = htrans;
      end
    end
  endtask

  task automatic resp_mon();
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (busy) chk(req_ready == 1'b0, "req_ready_busy", req_ready, 0);
        if (htrans == 2'b10) nonseq_cyc = ncyc;
        if (resp_valid) begin
          if (exp_rq.size() == 0) begin
            chk(1'b0, "resp_unexpected", 1, 0);
          end else begin
            e = exp_rq.pop_front();
            chk(resp_rdata === e.rdata, "resp_rdata", resp_rdata, e.rdata);
            chk(resp_err === e.err, "resp_err", resp_err, e.err);
          end
          resp_cnt++;
          resp_cyc = ncyc;
          busy = 1'b0;
        end
      end
    end
  endtask

  // Reference model: builds expected beats and response from line-level rules, then drives the request.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [127:0] line);
    logic [31:0]  base;
    logic [127:0] exp_line;
    int           off0, nok, naddr, w;
    bit           got;
    abeat_t       b;
    resp_t        r;
    base  = addr & ~32'hF;
    off0  = off0_of(addr);
    nok   = (cfg_err_beat >= 0) ? cfg_err_beat : 4;
    naddr = (cfg_err_beat >= 0) ? cfg_err_beat + 1 : 4;
    for (int k = 0; k < naddr; k++) begin
      w = (off0 + k) % 4;
      b.addr  = base + 32'(w * 4);
      b.trans = (k == 0) ? 2'b10 : 2'b11;
      b.wr    = wr;
      b.wd    = line[w*32 +: 32];
      exp_aq.push_back(b);
    end
    exp_line = last_rdata;
    for (int k = 0; k < nok; k++) begin
      w = (off0 + k) % 4;
      if (wr) rmem[widx(base) + w] = line[w*32 +: 32];
      else    exp_line[w*32 +: 32] = rmem[widx(base) + w];
    end
    if (!wr) last_rdata = exp_line;
    r.rdata = last_rdata;
    r.err   = (cfg_err_beat >= 0);
    exp_rq.push_back(r);

    @(posedge clk);
    #3;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = line;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    acc_cyc = ncyc;
    @(posedge clk);
    #3;
    req_valid = 1'b0;
    req_write = $urandom % 2;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    if (!got) begin
      chk(1'b0, "req_accept_timeout", 0, 1);
      exp_aq.delete();
      exp_rq.delete();
    end else begin
      busy = 1'b1;
    end
  endtask

  task automatic wait_done();
    int start;
    bit seen;
    start = resp_cnt;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_cnt != start) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      chk(1'b0, "resp_timeout", 0, 1);
      exp_rq.delete();
      busy = 1'b0;
    end
    chk(exp_aq.size() == 0, "addr_beats_left", exp_aq.size(), 0);
    exp_aq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(htrans == 2'b00, {tag, "_htrans"}, htrans, 0);
    chk(req_ready == 1'b0, {tag, "_req_ready"}, req_ready, 0);
    chk(resp_valid == 1'b0, {tag, "_resp_valid"}, resp_valid, 0);
    chk(resp_err == 1'b0, {tag, "_resp_err"}, resp_err, 0);
    chk(resp_rdata == '0, {tag, "_resp_rdata"}, resp_rdata, 0);
  endtask

  initial begin
    logic [127:0] line;
    logic [31:0]  a;
    for (int i = 0; i < 256; i++) begin
      smem[i] = (32'(i) * 32'h01000193) ^ 32'hA5A50000;
      rmem[i] = smem[i];
    end
    fork
      cycle_counter();
      slave_proc();
      resp_mon();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    chk(haddr == '0, "rst_haddr", haddr, 0);
    chk(hsize == 3'b010, "hsize", hsize, 3'b010);
    chk(hburst == 3'b010, "hburst", hburst, 3'b010);
    chk(hprot == 4'b0011, "hprot", hprot, 4'b0011);
    chk(hmastlock == 1'b0, "hmastlock", hmastlock, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(req_ready == 1'b1, "ready_after_rst", req_ready, 1);

    // Known line write then read-back at 0x0.
    line = 128'h5aa5f00f3cc3e11e_fedcba9876543210;
    issue(1'b1, 32'h0, line);
    wait_done();
    issue(1'b0, 32'h0, 128'h0);
    wait_done();
    chk(resp_rdata == line, "readback_line", resp_rdata, line);

    // Zero-wait read latency.
    issue(1'b0, 32'h100, 128'h0);
    wait_done();
    chk(nonseq_cyc - acc_cyc == 1, "lat_nonseq", nonseq_cyc - acc_cyc, 1);
    chk(resp_cyc - acc_cyc == 6, "lat_resp", resp_cyc - acc_cyc, 6);

    // Three wait states on beat 1 of a write, then read it back.
    cfg_wait_beat = 1;
    cfg_wait_n = 3;
    line = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    issue(1'b1, 32'h140, line);
    wait_done();
    cfg_wait_beat = -1;
    cfg_wait_n = 0;
    issue(1'b0, 32'h140, 128'h0);
    wait_done();
    chk(resp_rdata == line, "wait_write_readback", resp_rdata, line);

    // Read at 0x38: wrap order depends on critical-word build.
    issue(1'b0, 32'h38, 128'h0);
    wait_done();

    // ERROR on beat 1, then a clean request.
    cfg_err_beat = 1;
    issue(1'b0, 32'h200, 128'h0);
    wait_done();
    cfg_err_beat = -1;
    issue(1'b0, 32'h200, 128'h0);
    wait_done();

    // Reset during beat 2 of a read.
    issue(1'b0, 32'h80, 128'h0);
    repeat (3) @(negedge clk);
    busy = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_aq.delete();
    exp_rq.delete();
    last_rdata = '0;
    @(negedge clk);
    check_reset_outputs("midrst2");
    rst_n = 1'b1;
    @(negedge clk);
    chk(req_ready == 1'b1, "ready_after_midrst", req_ready, 1);
    issue(1'b0, 32'h80, 128'h0);
    wait_done();

    // Randomized traffic with random waits and occasional errors.
    for (int t = 0; t < 40; t++) begin
      a = (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
      line = {$urandom, $urandom, $urandom, $urandom};
      cfg_maxw = int'($urandom_range(0, 2));
      cfg_err_beat = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      issue(1'($urandom_range(0, 1)), a, line);
      wait_done();
    end
    cfg_err_beat = -1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
